// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-multiply pipeline.
// The input-memory stage uses the same helpers so address widths always agree.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUTPUT,
    DONE
  } state_t;

  // Never returns 0, so degenerate parameter sets still give legal vector widths.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  function automatic int k_bits(input int maxk);
    return clog2_min1(maxk + 1);
  endfunction

  function automatic int a_addr_bits(input int m, input int maxk);
    return clog2_min1(m * maxk);
  endfunction

  function automatic int b_addr_bits(input int maxk, input int n);
    return clog2_min1(maxk * n);
  endfunction

  function automatic int out_width(input int inw, input int maxk);
    return 2 * inw + $clog2(maxk);
  endfunction

endpackage

// File: rtl/mac_accum.sv
// Signed multiply-accumulate: INW x INW product sign-extended to OUTW and summed.
// acc_next exposes the value the accumulator takes at the coming edge.
module mac_accum
  import matmul_pkg::*;
#(
  parameter int INW  = 12,
  parameter int OUTW = out_width(12, 8)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic signed [INW-1:0]  a,
  input  logic signed [INW-1:0]  b,
  output logic signed [OUTW-1:0] acc_next
);

  logic signed [2*INW-1:0] product;
  logic signed [OUTW-1:0]  product_ext;
  logic signed [OUTW-1:0]  acc;

  assign product     = (2*INW)'(a) * (2*INW)'(b);
  assign product_ext = OUTW'(product);

  // Clear wins over enable so a new element never inherits a stale product.
  always_comb begin
    acc_next = acc;
    if (clear) begin
      acc_next = '0;
    end else if (enable) begin
      acc_next = acc + product_ext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/matmul_compute.sv
// Compute stage: reads A and B from synchronous memories, forms C = A*B with one
// MAC and streams C row-major over AXI-stream, then pulses compute_finished.
module matmul_compute
  import matmul_pkg::*;
#(
  parameter int INW  = 12,
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8,
  parameter int OUTW = out_width(INW, MAXK)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                matrices_loaded,
  input  logic [k_bits(MAXK)-1:0]             K,
  output logic                                compute_finished,
  output logic [a_addr_bits(M, MAXK)-1:0]     A_read_addr,
  input  logic signed [INW-1:0]               A_data,
  output logic [b_addr_bits(MAXK, N)-1:0]     B_read_addr,
  input  logic signed [INW-1:0]               B_data,
  output logic signed [OUTW-1:0]              AXIS_TDATA,
  output logic                                AXIS_TVALID,
  input  logic                                AXIS_TREADY
);

  localparam int K_BITS      = k_bits(MAXK);
  localparam int A_ADDR_BITS = a_addr_bits(M, MAXK);
  localparam int B_ADDR_BITS = b_addr_bits(MAXK, N);
  localparam int I_BITS      = clog2_min1(M);
  localparam int J_BITS      = clog2_min1(N);

  state_t state, state_next;

  logic [K_BITS-1:0]      k_reg, k_cnt;
  logic [I_BITS-1:0]      i_cnt;
  logic [J_BITS-1:0]      j_cnt, j_next;
  logic [A_ADDR_BITS-1:0] a_base, a_base_next, a_ptr;
  logic [B_ADDR_BITS-1:0] b_ptr;
  logic                   rd_valid;
  logic                   tvalid_reg;
  logic signed [OUTW-1:0] tdata_reg;
  logic signed [OUTW-1:0] acc_next;
  logic                   mac_clear;
  logic                   last_k, last_col, last_elem, accept;

  assign last_k      = (k_cnt == k_reg - K_BITS'(1));
  assign last_col    = (j_cnt == J_BITS'(N - 1));
  assign last_elem   = last_col && (i_cnt == I_BITS'(M - 1));
  assign accept      = (state == OUTPUT) && tvalid_reg && AXIS_TREADY;
  assign j_next      = last_col ? '0 : j_cnt + J_BITS'(1);
  assign a_base_next = last_col ? a_base + A_ADDR_BITS'(k_reg) : a_base;

  // Addresses sit at zero outside ISSUE so a stalled or idle stage issues no new reads.
  assign A_read_addr      = (state == ISSUE) ? a_ptr : '0;
  assign B_read_addr      = (state == ISSUE) ? b_ptr : '0;
  assign AXIS_TDATA       = tdata_reg;
  assign AXIS_TVALID      = tvalid_reg;
  assign compute_finished = (state == DONE);

  mac_accum #(
    .INW  (INW),
    .OUTW (OUTW)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear    (mac_clear),
    .enable   (rd_valid),
    .a        (A_data),
    .b        (B_data),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // K==0 skips the read phase entirely and streams zeros straight from OUTPUT.
  always_comb begin
    state_next = state;
    mac_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (matrices_loaded) begin
          mac_clear  = 1'b1;
          state_next = (K == '0) ? OUTPUT : ISSUE;
        end
      end
      ISSUE: begin
        if (last_k) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = OUTPUT;
      end
      OUTPUT: begin
        if (accept) begin
          mac_clear = 1'b1;
          if (last_elem) begin
            state_next = DONE;
          end else if (k_reg == '0) begin
            state_next = OUTPUT;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address pointers advance by running adds: +1 / +N per k step, +K per row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_reg      <= '0;
      k_cnt      <= '0;
      i_cnt      <= '0;
      j_cnt      <= '0;
      a_base     <= '0;
      a_ptr      <= '0;
      b_ptr      <= '0;
      rd_valid   <= 1'b0;
      tvalid_reg <= 1'b0;
      tdata_reg  <= '0;
    end else begin
      rd_valid <= (state == ISSUE);
      case (state)
        IDLE: begin
          if (matrices_loaded) begin
            k_reg      <= K;
            k_cnt      <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            a_base     <= '0;
            a_ptr      <= '0;
            b_ptr      <= '0;
            tdata_reg  <= '0;
            tvalid_reg <= (K == '0);
          end
        end
        ISSUE: begin
          if (!last_k) begin
            k_cnt <= k_cnt + K_BITS'(1);
            a_ptr <= a_ptr + A_ADDR_BITS'(1);
            b_ptr <= b_ptr + B_ADDR_BITS'(N);
          end
        end
        DRAIN: begin
          tdata_reg  <= acc_next;
          tvalid_reg <= 1'b1;
        end
        OUTPUT: begin
          if (accept) begin
            j_cnt      <= j_next;
            a_base     <= a_base_next;
            k_cnt      <= '0;
            a_ptr      <= a_base_next;
            b_ptr      <= B_ADDR_BITS'(j_next);
            tvalid_reg <= (k_reg == '0) && !last_elem;
            if (last_col) begin
              i_cnt <= i_cnt + I_BITS'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
